lc3b_mem_arbiter: RTL and testbench

- Shares the single-port unified memory between two requesters.
- Requester F is instruction fetch, driven during the FETCH/IR-load step.
- Requester D is data access for LDW/LDB/STW/STB, driven during the memory step.
- Sequences each access through a fixed number of memory wait states and returns a one-cycle acknowledge to the winner; the controller stalls its state machine until that ack arrives.

---
 rtl/lc3b_mem_arbiter_pkg.sv | 17 +
 rtl/lc3b_mem_arbiter_if.sv | 29 ++
 rtl/lc3b_mem_arbiter_rr_pick.sv | 30 +++
 rtl/lc3b_mem_arbiter.sv | 98 +++++++++
 tb/tb_lc3b_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3b unified-memory arbiter.
package lc3b_mem_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_ACK} arb_state_t;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic WEN_ASSERT   = 1'b0;
    localparam logic WEN_DEASSERT = 1'b1;

    function automatic logic [1:0] own_onehot(input logic own);
        return (own == OWN_D) ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter, bundled for port use.
interface lc3b_mem_arbiter_if #(parameter int AW = 16, parameter int DW = 16);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen_n;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    gnt;
    logic          busy;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_wen_n, gnt, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_wen_n, gnt, busy
    );
endinterface

// File: rtl/lc3b_mem_arbiter_rr_pick.sv
// Two-way request selector: round-robin on conflict, or D-always-wins when
// ARB_FIXED_PRIO_EN is defined.
module lc3b_rr_pick
    import lc3b_mem_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
    input  logic last_owner,
    output logic valid,
    output logic owner
);
`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_owner;
`endif

    always_comb begin
        valid = f_req | d_req;
        owner = OWN_F;
        if (f_req && d_req) begin
`ifdef ARB_FIXED_PRIO_EN
            owner = OWN_D;
`else
            owner = (last_owner == OWN_D) ? OWN_F : OWN_D;
`endif
        end else if (d_req) begin
            owner = OWN_D;
        end
    end
endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Fetch/data arbiter for the single-port LC-3b memory with fixed wait states.
// Conflict policy selectable with ARB_FIXED_PRIO_EN (see lc3b_rr_pick).
module lc3b_mem_arbiter
    import lc3b_mem_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    lc3b_mem_arbiter_if.slave  bus
);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    arb_state_t    state, state_nx;
    logic [3:0]    cnt;
    logic          owner, last_owner;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, f_rdata_q, d_rdata_q;
    logic          we_q;
    logic          pick_vld, pick_own;

    lc3b_rr_pick u_pick (
        .f_req      (bus.f_req),
        .d_req      (bus.d_req),
        .last_owner (last_owner),
        .valid      (pick_vld),
        .owner      (pick_own)
    );

    always_comb begin
        state_nx      = state;
        bus.f_ack     = 1'b0;
        bus.d_ack     = 1'b0;
        bus.gnt       = 2'b00;
        bus.busy      = 1'b0;
        bus.mem_wen_n = WEN_DEASSERT;
        unique case (state)
            ARB_IDLE: if (pick_vld) state_nx = ARB_ACCESS;
            ARB_ACCESS: begin
                bus.gnt  = own_onehot(owner);
                bus.busy = 1'b1;
                if (we_q) bus.mem_wen_n = WEN_ASSERT;
                if (cnt == 4'd0) state_nx = ARB_ACK;
            end
            ARB_ACK: begin
                bus.gnt   = own_onehot(owner);
                bus.busy  = 1'b1;
                bus.f_ack = (owner == OWN_F);
                bus.d_ack = (owner == OWN_D);
                state_nx  = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    // Memory side always comes from the latches, so requester inputs may
    // wander during an access without reaching the bus.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            cnt        <= 4'd0;
            owner      <= OWN_F;
            last_owner <= OWN_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ARB_IDLE: if (pick_vld) begin
                    owner   <= pick_own;
                    cnt     <= CNT_LOAD;
                    addr_q  <= (pick_own == OWN_D) ? bus.d_addr : bus.f_addr;
                    we_q    <= (pick_own == OWN_D) & bus.d_we;
                    wdata_q <= (pick_own == OWN_D) ? bus.d_wdata : '0;
                end
                ARB_ACCESS: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else begin
                        last_owner <= owner;
                        if (owner == OWN_D) d_rdata_q <= bus.mem_rdata;
                        else                f_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench: reset, table of single transactions, directed corner
// sequences, then random traffic against a transaction-level scoreboard.
module tb_lc3b_mem_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc3b_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    lc3b_mem_arbiter #(.WAIT_STATES(W), .AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    assign bus.mem_rdata = memfn(bus.mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic arb_pick(input logic f, input logic d, input logic last);
        if (f && d) begin
`ifdef ARB_FIXED_PRIO_EN
            return 1'b1;
`else
            return ~last;
`endif
        end
        return d;
    endfunction

    // Transaction-level model: t counts cycles since the grant edge
    // (1..W = memory cycles, W+1 = acknowledge cycle, 0 = idle).
    int          t;
    logic        m_own, m_last, m_we;
    logic [15:0] m_addr, m_wd, m_frd, m_drd;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t <= 0; m_last <= 1'b1; m_frd <= '0; m_drd <= '0;
            m_addr <= '0; m_wd <= '0; m_we <= 1'b0; m_own <= 1'b0;
        end else if (t == 0) begin
            if (bus.f_req || bus.d_req) begin
                t      <= 1;
                m_own  <= arb_pick(bus.f_req, bus.d_req, m_last);
                m_addr <= arb_pick(bus.f_req, bus.d_req, m_last) ? bus.d_addr : bus.f_addr;
                m_we   <= arb_pick(bus.f_req, bus.d_req, m_last) & bus.d_we;
                m_wd   <= bus.d_wdata;
            end
        end else if (t == W + 1) begin
            t <= 0;
        end else begin
            if (t == W) begin
                if (m_own) m_drd <= memfn(m_addr);
                else       m_frd <= memfn(m_addr);
                m_last <= m_own;
            end
            t <= t + 1;
        end
    end

    logic [1:0] e_gnt;
    logic       e_acc;
    always @(negedge clk) begin
        if (chk_en) begin
            e_gnt = (t == 0) ? 2'b00 : (m_own ? 2'b10 : 2'b01);
            e_acc = (t >= 1) && (t <= W);
            chk("ctl", {27'd0, bus.gnt, bus.busy, bus.f_ack, bus.d_ack, bus.mem_wen_n},
                {27'd0, e_gnt, t != 0, (t == W + 1) && !m_own, (t == W + 1) && m_own,
                 !(e_acc && m_we)});
            chk("rdata", {bus.f_rdata, bus.d_rdata}, {m_frd, m_drd});
            if (t != 0) chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, m_addr});
            if (e_acc && m_we) chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, m_wd});
        end
    end

    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_wen_lo;
    } vec_t;

    vec_t tbl[4];

    task automatic run_vec(input vec_t v, input string nm);
        int n, lo;
        logic got;
        @(negedge clk);
        if (v.port) begin
            bus.d_req = 1'b1; bus.d_addr = v.addr; bus.d_we = v.we; bus.d_wdata = v.wd;
        end else begin
            bus.f_req = 1'b1; bus.f_addr = v.addr;
        end
        n = 0; lo = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.mem_wen_n == 1'b0) begin
                lo++;
                chk({nm, ".wr_addr"}, {16'd0, bus.mem_addr}, {16'd0, v.addr});
                chk({nm, ".wr_data"}, {16'd0, bus.mem_wdata}, {16'd0, v.wd});
            end
            got = v.port ? bus.d_ack : bus.f_ack;
        end
        chk({nm, ".latency"}, n, v.exp_lat);
        chk({nm, ".wen_cycles"}, lo, v.exp_wen_lo);
        chk({nm, ".rdata"}, {16'd0, v.port ? bus.d_rdata : bus.f_rdata}, {16'd0, v.exp_rd});
        bus.f_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    endtask

    int   order[$];
    int   ack_t[$];
    int   cyc;
    logic exp_ord [4];

    initial begin
        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_addr = '0;
        bus.d_we = 0; bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset", {bus.gnt, bus.busy, bus.f_ack, bus.d_ack, bus.mem_wen_n, bus.mem_addr, 10'd0},
            {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 10'd0});
        chk("reset.data", {bus.mem_wdata, bus.f_rdata}, 32'h0);
        chk("reset.drd", {16'd0, bus.d_rdata}, 32'h0);
        chk_en = 1'b1;
        rst = 1'b0;

        tbl[0] = '{1'b0, 16'h3000, 1'b0, 16'h0000, 16'h1234, 3, 0};
        tbl[1] = '{1'b1, 16'h4002, 1'b1, 16'hBEEF, 16'h1A58, 3, 2};
        tbl[2] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 16'h5B5A, 3, 0};
        tbl[3] = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hA5A5, 3, 0};
        for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Simultaneous requests straight out of reset, both held.
`ifdef ARB_FIXED_PRIO_EN
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.f_req = 1; bus.f_addr = 16'h1000; bus.d_req = 1; bus.d_addr = 16'h2000; bus.d_we = 0;
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            @(negedge clk);
            if (bus.f_ack) order.push_back(0);
            if (bus.d_ack) order.push_back(1);
        end
        chk("conflict.count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk($sformatf("conflict.order%0d", i), order[i], {31'd0, exp_ord[i]});
        bus.f_req = 0; bus.d_req = 0;

        // Address change mid-access must not reach the memory bus.
        @(negedge clk); @(negedge clk);
        bus.d_req = 1; bus.d_addr = 16'h4100; bus.d_we = 0;
        @(negedge clk); bus.d_addr = 16'h5555;
        @(negedge clk); chk("midacc.addr", {16'd0, bus.mem_addr}, 32'h4100);
        @(negedge clk); chk("midacc.ack", {31'd0, bus.d_ack}, 32'd1);
        chk("midacc.rdata", {16'd0, bus.d_rdata}, 32'h1B5A);
        bus.d_req = 0;

        // Reset in the first memory cycle of a store aborts it silently.
        @(negedge clk);
        bus.d_req = 1; bus.d_addr = 16'h4200; bus.d_we = 1; bus.d_wdata = 16'h1111;
        @(negedge clk); chk("abort.wen_low", {31'd0, bus.mem_wen_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.state", {27'd0, bus.gnt, bus.busy, bus.d_ack, bus.mem_wen_n}, {27'd0, 2'b00, 1'b0, 1'b0, 1'b1});
        rst = 1'b0; bus.d_req = 0; bus.d_we = 0;
        repeat (4) @(negedge clk);
        run_vec(tbl[0], "post_abort");

        // Fetch held continuously: acks every W+2 cycles.
        @(negedge clk);
        bus.f_req = 1; bus.f_addr = 16'h2000;
        cyc = 0;
        for (int i = 0; i < 40 && ack_t.size() < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.f_ack) ack_t.push_back(cyc);
            if (!bus.busy) chk("held.idle_gnt", {30'd0, bus.gnt}, 32'd0);
        end
        chk("held.count", ack_t.size(), 4);
        for (int i = 1; i < ack_t.size(); i++)
            chk($sformatf("held.period%0d", i), ack_t[i] - ack_t[i-1], W + 2);
        bus.f_req = 0;
        @(negedge clk);

        // Random traffic; the scoreboard checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.f_req) begin
                if (bus.f_ack) begin
                    if ($urandom_range(1, 0) == 0) bus.f_req = 0;
                    else bus.f_addr = 16'($urandom);
                end
            end else if ($urandom_range(3, 0) == 0) begin
                bus.f_req = 1; bus.f_addr = 16'($urandom);
            end
            if (bus.d_req) begin
                if (bus.d_ack) begin
                    if ($urandom_range(1, 0) == 0) bus.d_req = 0;
                    else begin
                        bus.d_addr = 16'($urandom); bus.d_we = 1'($urandom);
                        bus.d_wdata = 16'($urandom);
                    end
                end
            end else if ($urandom_range(3, 0) == 0) begin
                bus.d_req = 1; bus.d_addr = 16'($urandom);
                bus.d_we = 1'($urandom); bus.d_wdata = 16'($urandom);
            end
        end
        bus.f_req = 0; bus.d_req = 0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
